seq_alu: RTL

- Parametrised, clocked successor to the datapath ALU.
- Supports the existing op set (AND, OR, ADD, SUB, PassB) and adds logical shifts and an iterative shift-add multiplier.
- Uses a Start/Busy/Done handshake and registers the result and Zero flag.
- Sits in the execute stage. The controller stalls the PC while Busy is high.

---
 rtl/seq_alu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: clocked execute-stage ALU with a Start/Busy/Done handshake.
// Most ops finish in one cycle. MUL is an iterative shift-add unit that takes
// N cycles and holds Busy high meanwhile, so the controller can stall the PC.
// BusW, Zero and (optionally) the flags are registered and change only when
// a new result completes.
// Optional feature: define SEQ_ALU_FLAGS_EN to add the registered Carry,
// Overflow and Negative outputs.
module seq_alu #(
    parameter int N   = 64,
    parameter int SHW = 6
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [3:0]   ALUCtrl,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Busy,
    output logic         Done
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic         Carry,
    output logic         Overflow,
    output logic         Negative
`endif
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LSL   = 4'b0011;
    localparam logic [3:0] OP_LSR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MUL  = 1'b1;

    logic           state_q, state_d;
    logic [N-1:0]   busw_q, busw_d;
    logic           zero_q, zero_d;
    logic           done_q, done_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [SHW-1:0] count_q, count_d;

    logic [SHW-1:0] sh_amt;
    logic [N-1:0]   op_res;
    logic [N-1:0]   mul_sum;

`ifdef SEQ_ALU_FLAGS_EN
    logic [N:0] sum_ext, diff_ext, sll_ext, srl_ext;
    logic       op_c, op_v;
    logic       carry_q, carry_d;
    logic       ovf_q, ovf_d;
    logic       neg_q, neg_d;
`endif

    // Shift amount comes from the low bits of BusB; upper bits are ignored.
    assign sh_amt = BusB[SHW-1:0];

    // One multiply step: the multiplier register is shifted right each cycle,
    // so bit 0 is always the current multiplier bit, and the multiplicand is
    // shifted left in step with it (equivalent to adding A<<count).
    assign mul_sum = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    // Combinational result (and flags) for the single-cycle opcodes.
    always_comb begin
        op_res = '0;
`ifdef SEQ_ALU_FLAGS_EN
        op_c     = 1'b0;
        op_v     = 1'b0;
        sum_ext  = {1'b0, BusA} + {1'b0, BusB};
        diff_ext = {1'b0, BusA} + {1'b0, ~BusB} + {{N{1'b0}}, 1'b1};
        sll_ext  = {1'b0, BusA} << sh_amt;
        srl_ext  = {BusA, 1'b0} >> sh_amt;
`endif
        case (ALUCtrl)
            OP_AND:   op_res = BusA & BusB;
            OP_OR:    op_res = BusA | BusB;
            OP_PASSB: op_res = BusB;
`ifdef SEQ_ALU_FLAGS_EN
            OP_ADD: begin
                op_res = sum_ext[N-1:0];
                op_c   = sum_ext[N];
                op_v   = (BusA[N-1] == BusB[N-1]) && (sum_ext[N-1] != BusA[N-1]);
            end
            OP_SUB: begin
                op_res = diff_ext[N-1:0];
                op_c   = diff_ext[N];
                op_v   = (BusA[N-1] != BusB[N-1]) && (diff_ext[N-1] != BusA[N-1]);
            end
            OP_LSL: begin
                op_res = sll_ext[N-1:0];
                op_c   = sll_ext[N];
            end
            OP_LSR: begin
                op_res = srl_ext[N:1];
                op_c   = srl_ext[0];
            end
`else
            OP_ADD:   op_res = BusA + BusB;
            OP_SUB:   op_res = BusA - BusB;
            OP_LSL:   op_res = BusA << sh_amt;
            OP_LSR:   op_res = BusA >> sh_amt;
`endif
            default:  op_res = '0;
        endcase
    end

    // Next-state logic for the IDLE/MUL controller and the result registers.
    always_comb begin
        state_d = state_q;
        busw_d  = busw_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        count_d = count_q;
`ifdef SEQ_ALU_FLAGS_EN
        carry_d = carry_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (ALUCtrl == OP_MUL) begin
                        a_sh_d  = BusA;
                        b_sh_d  = BusB;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ST_MUL;
                    end else begin
                        busw_d = op_res;
                        zero_d = (op_res == '0);
                        done_d = 1'b1;
`ifdef SEQ_ALU_FLAGS_EN
                        carry_d = op_c;
                        ovf_d   = op_v;
                        neg_d   = op_res[N-1];
`endif
                    end
                end
            end
            ST_MUL: begin
                acc_d   = mul_sum;
                a_sh_d  = a_sh_q << 1;
                b_sh_d  = b_sh_q >> 1;
                count_d = count_q + SHW'(1);
                if (&count_q) begin
                    busw_d  = mul_sum;
                    zero_d  = (mul_sum == '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef SEQ_ALU_FLAGS_EN
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    neg_d   = mul_sum[N-1];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset abandons any multiply in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            busw_q  <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            acc_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            count_q <= '0;
`ifdef SEQ_ALU_FLAGS_EN
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busw_q  <= busw_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            count_q <= count_d;
`ifdef SEQ_ALU_FLAGS_EN
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign BusW = busw_q;
    assign Zero = zero_q;
    assign Done = done_q;
    assign Busy = (state_q == ST_MUL);

`ifdef SEQ_ALU_FLAGS_EN
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Negative = neg_q;
`endif

endmodule
